// File: rtl/fletcher_pkg.sv
// -----------------------------------------------------------------------------
// fletcher_pkg
//   Shared types and helpers for the streaming Fletcher checksum engine.
//   - state_t      : two-state control FSM encoding (ACCUM, SEND)
//   - modulus()    : Fletcher modulus M = 2^nbits - 1 for a given word width
//   - nbits_legal(): word widths the engine supports (8, 16, 32); used by the
//                    top level to stop elaboration on an unsupported width
// -----------------------------------------------------------------------------
package fletcher_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        SEND  = 1'b1
    } state_t;

    // Modulus for an nbits-wide word; 64-bit result covers every legal width.
    function automatic logic [63:0] modulus(input int nbits);
        return (64'd1 << nbits) - 64'd1;
    endfunction

    function automatic bit nbits_legal(input int nbits);
        return (nbits == 8) || (nbits == 16) || (nbits == 32);
    endfunction

endpackage

// File: rtl/fletcher_modadd.sv
// -----------------------------------------------------------------------------
// fletcher_modadd
//   Combinational modular adder for Fletcher sums: sum = (a + b) mod M,
//   M = 2^NBITS - 1, result kept canonical in [0, M-1].
//
//   Ports:
//     a   [NBITS-1:0]  in   canonical running sum
//     b   [NBITS-1:0]  in   addend (may equal M, which is congruent to 0)
//     sum [NBITS-1:0]  out  canonical modular sum
//
//   Parameters:
//     NBITS  word width (8, 16 or 32)
// -----------------------------------------------------------------------------
module fletcher_modadd
    import fletcher_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic [NBITS-1:0] sum
);

    localparam logic [NBITS-1:0] MOD = NBITS'(modulus(NBITS));

    logic [NBITS:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};

    // Subtracting M = 2^NBITS - 1 is an end-around carry: when the add
    // overflows, drop the carry and add one. A raw result of exactly M
    // (no carry, all ones) folds to zero to stay canonical.
    always_comb begin
        if (raw[NBITS]) begin
            sum = raw[NBITS-1:0] + NBITS'(1);
        end else if (raw[NBITS-1:0] == MOD) begin
            sum = '0;
        end else begin
            sum = raw[NBITS-1:0];
        end
    end

endmodule

// File: rtl/fletcher_stream_unit.sv
// -----------------------------------------------------------------------------
// fletcher_stream_unit
//   Streaming Fletcher-16/32/64 checksum engine over variable-length blocks.
//   Words arrive on a val/rdy stream, a block ends on the word flagged with
//   recv_last, and the checksum {sum2, sum1} leaves on a val/rdy stream one
//   cycle after the last word is accepted.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous reset, active low
//     recv_val   in   input word valid
//     recv_rdy   out  engine can accept a word
//     recv_msg   in   [NBITS-1:0] data word
//     recv_last  in   word is the final one of its block
//     send_val   out  checksum valid
//     send_rdy   in   sink accepts the checksum
//     send_msg   out  [2*NBITS-1:0] checksum, sum2 in the upper half
//
//   Parameters:
//     NBITS      word width: 8, 16 or 32
//
//   Build option:
//     FLETCHER_STREAM_UNIT_OVERLAP_EN
//       Defined  : one-entry result buffer lets the next block accumulate
//                  while the previous checksum waits at the output.
//       Undefined: accumulator stalls in SEND until the checksum is taken.
// -----------------------------------------------------------------------------
module fletcher_stream_unit
    import fletcher_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               recv_val,
    output logic               recv_rdy,
    input  logic [NBITS-1:0]   recv_msg,
    input  logic               recv_last,
    output logic               send_val,
    input  logic               send_rdy,
    output logic [2*NBITS-1:0] send_msg
);

    if (!nbits_legal(NBITS)) begin : g_nbits_check
        $error("fletcher_stream_unit: NBITS must be 8, 16 or 32");
    end

    state_t             state_reg;
    state_t             state_next;
    logic [NBITS-1:0]   sum1_reg;
    logic [NBITS-1:0]   sum1_next;
    logic [NBITS-1:0]   sum2_reg;
    logic [NBITS-1:0]   sum2_next;
    logic [NBITS-1:0]   sum1_add;
    logic [NBITS-1:0]   sum2_add;
    logic [2*NBITS-1:0] send_msg_reg;
    logic [2*NBITS-1:0] send_msg_next;
    logic               recv_fire;

    // sum1' = sum1 + word; sum2' = sum2 + sum1' (chained through the first adder)
    fletcher_modadd #(.NBITS(NBITS)) u_add_sum1 (
        .a   (sum1_reg),
        .b   (recv_msg),
        .sum (sum1_add)
    );

    fletcher_modadd #(.NBITS(NBITS)) u_add_sum2 (
        .a   (sum2_reg),
        .b   (sum1_add),
        .sum (sum2_add)
    );

    // recv_rdy is forced low while reset is held; otherwise it comes only from
    // registered state, so send_rdy never reaches it combinationally.
    assign recv_rdy  = reset && (state_reg == ACCUM);
    assign recv_fire = recv_val && recv_rdy;
    assign send_msg  = send_msg_reg;

`ifdef FLETCHER_STREAM_UNIT_OVERLAP_EN

    // send_msg_reg acts as the one-entry result buffer. ACCUM keeps taking
    // words while the buffer is full; only a last word that finds the buffer
    // full and not draining has nowhere to go. It then parks in sum1/sum2 and
    // the FSM waits in SEND (recv_rdy low) until the buffer drains.
    logic buf_full_reg;
    logic buf_full_next;

    assign send_val = buf_full_reg;

    always_comb begin
        state_next    = state_reg;
        sum1_next     = sum1_reg;
        sum2_next     = sum2_reg;
        send_msg_next = send_msg_reg;
        buf_full_next = buf_full_reg;

        if (send_val && send_rdy) begin
            buf_full_next = 1'b0;
        end

        case (state_reg)
            ACCUM: begin
                if (recv_fire) begin
                    if (recv_last && (!buf_full_reg || send_rdy)) begin
                        send_msg_next = {sum2_add, sum1_add};
                        buf_full_next = 1'b1;
                        sum1_next     = '0;
                        sum2_next     = '0;
                    end else begin
                        sum1_next = sum1_add;
                        sum2_next = sum2_add;
                        if (recv_last) begin
                            state_next = SEND;
                        end
                    end
                end
            end
            SEND: begin
                // Buffer is always full here, so send_rdy means it drains now.
                if (send_rdy) begin
                    send_msg_next = {sum2_reg, sum1_reg};
                    buf_full_next = 1'b1;
                    sum1_next     = '0;
                    sum2_next     = '0;
                    state_next    = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full_reg <= 1'b0;
        end else begin
            buf_full_reg <= buf_full_next;
        end
    end

`else

    assign send_val = (state_reg == SEND);

    always_comb begin
        state_next    = state_reg;
        sum1_next     = sum1_reg;
        sum2_next     = sum2_reg;
        send_msg_next = send_msg_reg;

        case (state_reg)
            ACCUM: begin
                if (recv_fire) begin
                    if (recv_last) begin
                        send_msg_next = {sum2_add, sum1_add};
                        sum1_next     = '0;
                        sum2_next     = '0;
                        state_next    = SEND;
                    end else begin
                        sum1_next = sum1_add;
                        sum2_next = sum2_add;
                    end
                end
            end
            SEND: begin
                if (send_rdy) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ACCUM;
            sum1_reg     <= '0;
            sum2_reg     <= '0;
            send_msg_reg <= '0;
        end else begin
            state_reg    <= state_next;
            sum1_reg     <= sum1_next;
            sum2_reg     <= sum2_next;
            send_msg_reg <= send_msg_next;
        end
    end

endmodule
